// File: rtl/prod_bcd_converter_pkg.sv
// Shared state encoding and constants for the sequential binary-to-BCD converter.
package prod_bcd_converter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int IN_W_DEF   = 8;
    localparam int ND_DEF     = 3;
    localparam int ADJ_THRESH = 5;

endpackage

// File: rtl/prod_bcd_converter_bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_digit_adj
    import prod_bcd_converter_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'(ADJ_THRESH)) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/prod_bcd_converter.sv
// Sequential double-dabble converter: one shift per clock, IN_W shifts per conversion.
// Handshake: start is sampled only in IDLE; busy is high while shifting; done pulses once with bcd valid.
module prod_bcd_converter
    import prod_bcd_converter_pkg::*;
#(
    parameter int IN_W = IN_W_DEF,
    parameter int ND   = ND_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic            busy,
    output logic            done,
    output logic [4*ND-1:0] bcd,
    output state_t          dbg_state
);

    localparam int SR_W  = 4*ND + IN_W;
    localparam int CNT_W = $clog2(IN_W + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [SR_W-1:0]  r_sr;
    logic [SR_W-1:0]  w_adj_sr;
    logic [SR_W-1:0]  w_shift_sr;
    logic [CNT_W-1:0] r_cnt;
    logic [4*ND-1:0]  r_bcd;
    logic             r_done;
    logic             w_last;

    // Scratch digits sit above the binary shift register; correct each one, pass the binary part through.
    for (genvar g = 0; g < ND; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_sr[IN_W + 4*g +: 4]),
            .o_digit (w_adj_sr[IN_W + 4*g +: 4])
        );
    end
    assign w_adj_sr[IN_W-1:0] = r_sr[IN_W-1:0];
    assign w_shift_sr         = {w_adj_sr[SR_W-2:0], 1'b0};
    assign w_last             = (r_cnt == CNT_W'(IN_W - 1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)  w_next_state = SHIFT;
            SHIFT:   if (w_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sr  <= {{(4*ND){1'b0}}, bin};
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_sr  <= w_shift_sr;
                    r_cnt <= r_cnt + 1'b1;
                    // bcd is only updated on completion so it never shows partial scratch values.
                    if (w_last) begin
                        r_bcd  <= w_shift_sr[SR_W-1 -: 4*ND];
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == SHIFT);
    assign done      = r_done;
    assign bcd       = r_bcd;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_prod_bcd_converter.sv
// Directed and exhaustive checks of the sequential BCD converter against hand values and a decimal model.
module tb_prod_bcd_converter;
    import prod_bcd_converter_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    state_t      dbg_state;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];

    prod_bcd_converter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // driver: called at a negedge; start is sampled at the next posedge, then bin is scrambled
    task automatic kick(input logic [7:0] v);
        start = 1'b1;
        bin   = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bin   = 8'($urandom_range(0, 255));
    endtask

    // waits for done (bounded), checks latency and that busy was high throughout the run
    task automatic wait_done(input string tag, input int exp_lat);
        int   lat;
        logic busy_ok;
        lat     = 0;
        busy_ok = busy;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy_run"}, busy_ok, 1'b1);
        check({tag, "_busy_in_done"}, busy, 1'b0);
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int n;
        int dig_ok;
        logic [11:0] e;

        rst   = 1'b1;
        start = 1'b1;
        bin   = 8'd77;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bcd", bcd, 12'h000);
        check("rst_state", dbg_state, IDLE);
        @(negedge clk);
        check("start_with_rst_ignored", busy, 1'b0);

        // directed vectors
        kick(8'd0);   wait_done("bin0", 8);   check("bin0_bcd", bcd, 12'h000);
        @(negedge clk); check("bin0_done_width", done, 1'b0);
        kick(8'd225); wait_done("bin225", 8); check("bin225_bcd", bcd, 12'h225);
        kick(8'd255); wait_done("bin255", 8); check("bin255_bcd", bcd, 12'h255);
        kick(8'd99);  wait_done("bin99", 8);  check("bin99_bcd", bcd, 12'h099);
        kick(8'd100); wait_done("bin100", 8); check("bin100_bcd", bcd, 12'h100);
        @(negedge clk); check("bcd_holds", bcd, 12'h100);

        // start while busy is ignored
        kick(8'd37);
        @(negedge clk);
        start = 1'b1; bin = 8'd200;
        @(negedge clk);
        start = 1'b0;
        check("ign_bcd_not_mid", bcd, 12'h100);
        count_done(14, n);
        check("ign_done_count", n, 1);
        check("ign_bcd", bcd, 12'h037);

        // reset aborts an in-progress conversion
        kick(8'd142);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_bcd", bcd, 12'h000);
        check("abort_done", done, 1'b0);
        count_done(12, n);
        check("abort_no_done", n, 0);
        kick(8'd58); wait_done("after_abort", 8); check("after_abort_bcd", bcd, 12'h058);

        // back-to-back: start accepted in the done cycle
        @(negedge clk);
        kick(8'd12); wait_done("b2b_first", 8); check("b2b_first_bcd", bcd, 12'h012);
        kick(8'd81); wait_done("b2b_second", 8); check("b2b_second_bcd", bcd, 12'h081);

        // exhaustive against the decimal model
        for (int v = 0; v < 256; v++) begin
            @(negedge clk);
            exp_q.push_back(ref_bcd(v));
            kick(8'(v));
            wait_done("exh", 8);
            e = exp_q.pop_front();
            check($sformatf("exh_bcd_%0d", v), bcd, e);
            dig_ok = (bcd[3:0] <= 4'd9) && (bcd[7:4] <= 4'd9) && (bcd[11:8] <= 4'd9);
            check($sformatf("exh_digits_%0d", v), dig_ok, 1);
            @(negedge clk);
            check($sformatf("exh_done_width_%0d", v), done, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prod_bcd_converter.md
PROD_BCD_CONVERTER -- requirements
Module: prod_bcd_converter

Interface
REQ-001 Parameter: IN_W, default 8, binary input width; 8 matches the 4x4 multiplier product.
REQ-002 Parameter: ND, default 3, number of BCD output digits; ND SHALL satisfy 10^ND > 2^IN_W - 1.
REQ-003 Port: clk, input, 1, the single clock; all state SHALL update on the rising edge.
REQ-004 Port: rst, input, 1; reset is synchronous and active-high.
REQ-005 Port: start, input, 1, request to convert bin; sampled only in IDLE.
REQ-006 Port: bin, input, IN_W, unsigned binary value (the multiplier product p[7:0]).
REQ-007 Port: busy, output, 1, high while a conversion is in progress.
REQ-008 Port: done, output, 1, single-cycle pulse marking a new valid bcd.
REQ-009 Port: bcd, output, 4*ND, packed BCD result; bcd[3:0] is ones, [7:4] tens, [11:8] hundreds.

Function
REQ-010 Algorithm SHALL be sequential double-dabble: one shift per clock, IN_W shifts per conversion.
REQ-011 FSM states SHALL be IDLE and SHIFT, and no others.
REQ-012 IDLE, start=1 at edge k: capture bin into a shift register, clear the digit scratch, clear the counter, go to SHIFT.
REQ-013 Each SHIFT edge: add 3 to every scratch digit >= 5, then shift {scratch, shreg} left by 1, then increment the counter.
REQ-014 On the IN_W-th SHIFT edge (edge k+IN_W): load bcd with the final scratch value, set done=1, return to IDLE.
REQ-015 Latency: done SHALL be high exactly in the cycle following edge k+IN_W (8 cycles after start is sampled at defaults).
REQ-016 busy SHALL equal (state==SHIFT), registered: high after edge k through edge k+IN_W inclusive, low in the done cycle.
REQ-017 done SHALL be high for exactly one cycle per conversion and never while busy=1.
REQ-018 start while busy=1 SHALL be ignored; no queuing; bin changes during SHIFT SHALL NOT affect the result.
REQ-019 start=1 in the done cycle (state IDLE) SHALL be accepted, so back-to-back conversions are allowed.
REQ-020 bcd SHALL hold the last completed result until the next completion; it SHALL NOT show intermediate scratch values.
REQ-021 Every output digit SHALL be 0..9 for all inputs 0..2^IN_W-1.
REQ-022 Counter width SHALL be clog2(IN_W+1); it SHALL not wrap within a conversion.

Reset
REQ-023 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, bcd=0, scratch=0, shreg=0, counter=0.
REQ-024 rst SHALL take priority over start and over an in-progress SHIFT; an aborted conversion produces no done.
REQ-025 start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, SHIFT) and the constants IN_W_DEF=8, ND_DEF=3, and ADJ_THRESH=5.
REQ-027 A single sub-module, bcd_digit_adj (4-bit in, 4-bit out, add 3 if >= 5), SHALL be instantiated ND times.
REQ-028 Datapath SHALL be one (4*ND+IN_W)-bit shift register plus the counter; no division or modulo operators.

Verification
REQ-029 bin=0, start pulse -> done 8 cycles later, bcd=12'h000.
REQ-030 bin=225 (15*15, max product) -> bcd=12'h225; bin=255 -> bcd=12'h255; bin=99 -> 12'h099; bin=100 -> 12'h100.
REQ-031 Exhaustive 0..255 against a reference model: every digit <= 9 and done width = 1 cycle.
REQ-032 bin=37 start, then start with bin=200 at cycle +3 -> ignored; result 12'h037 and a single done pulse.
REQ-033 bin=142 start, rst at cycle +4 -> no done, bcd=0, busy=0; a new start with bin=58 -> 12'h058.
REQ-034 bin=12 conversion, start with bin=81 in its done cycle -> done again 8 cycles later with bcd=12'h081.
